// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver producing one byte per frame.
// Default build receives 8N1 frames. Define UART_RX_PARITY_EN to receive
// 8E1 frames; a parity mismatch then pulses parity_err instead of valid.
// All outputs are registered. An input line held low after a bad stop bit
// parks the FSM in BREAK so it cannot retrigger a new frame.
module uart_rx_byte #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    output logic [N-1:0] data,
    output logic         busy,
    output logic         valid,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_ZERO      = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE       = IW'(1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd5
`endif
    } state_t;

    // Even parity of a data word: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [N-1:0] bits);
        return ^bits;
    endfunction

    logic [1:0]    rx_sync_r;
    logic          rx_s;
    state_t        state_r,     state_nxt;
    logic [CW-1:0] cnt_r,       cnt_nxt;
    logic [IW-1:0] idx_r,       idx_nxt;
    logic [N-1:0]  shift_r,     shift_nxt;
    logic [N-1:0]  data_r,      data_nxt;
    logic          busy_r,      busy_nxt;
    logic          valid_r,     valid_nxt;
    logic          frame_err_r, frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_r,    par_bad_nxt;
    logic          parity_err_r, parity_err_nxt;
`endif

    assign rx_s = rx_sync_r[1];

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
        end
    end

    // Next-state, sampling and output-pulse decisions for the frame FSM.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r + CNT_ONE;
        idx_nxt       = idx_r;
        shift_nxt     = shift_r;
        data_nxt      = data_r;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt    = par_bad_r;
        parity_err_nxt = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_nxt = CNT_ZERO;
                idx_nxt = IDX_ZERO;
`ifdef UART_RX_PARITY_EN
                par_bad_nxt = 1'b0;
`endif
                if (!rx_s) begin
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    // A line already back high at mid start bit was a glitch.
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_BIT_LAST) begin
                    cnt_nxt   = CNT_ZERO;
                    shift_nxt = {rx_s, shift_r[N-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_nxt = IDX_ZERO;
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == CNT_BIT_LAST) begin
                    cnt_nxt     = CNT_ZERO;
                    par_bad_nxt = (rx_s != even_parity(shift_r));
                    state_nxt   = ST_STOP;
                end else begin
                    state_nxt = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == CNT_BIT_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_r) begin
                            parity_err_nxt = 1'b1;
                        end else begin
                            data_nxt  = shift_r;
                            valid_nxt = 1'b1;
                        end
`else
                        data_nxt  = shift_r;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        frame_err_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_nxt = par_bad_r;
`endif
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_nxt = CNT_ZERO;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_BREAK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
                idx_nxt   = IDX_ZERO;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, datapath and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= IDX_ZERO;
            shift_r     <= {N{1'b0}};
            data_r      <= {N{1'b0}};
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            idx_r       <= idx_nxt;
            shift_r     <= shift_nxt;
            data_r      <= data_nxt;
            busy_r      <= busy_nxt;
            valid_r     <= valid_nxt;
            frame_err_r <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= par_bad_nxt;
            parity_err_r <= parity_err_nxt;
`endif
        end
    end

    assign data      = data_r;
    assign busy      = busy_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with CLKS_PER_BIT=16. Expected bytes go
// into a scoreboard queue when a good frame is sent and are popped when
// valid pulses. Honours UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_byte;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BUSY = 8 + 10 * CPB;
`else
    localparam int FRAME_BUSY = 8 + 9 * CPB;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       busy;
    logic       valid;
    logic       frame_err;
    logic       parity_err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         perr_cnt   = 0;
    int         cur_busy   = 0;
    int         last_busy  = 0;
    logic       prev_valid = 1'b0;

    uart_rx_byte #(.N(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .busy       (busy),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic send_bit(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, parity (8E1 build only), stop phase.
    task automatic send_byte(input logic [7:0] b, input logic par, input logic stop_v, input int stop_len);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bit(par, CPB);
`else
        if (par === 1'bx) send_bit(1'b1, 1);
`endif
        send_bit(stop_v, stop_len);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    // Output monitor: counts pulses, tracks busy length, drains the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                valid_cnt++;
                check("valid_busy_low", {31'd0, busy}, 32'd0);
                check("valid_width", {31'd0, prev_valid}, 32'd0);
                check_rng("sb_nonempty", exp_q.size(), 1, 64);
                if (exp_q.size() > 0) check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
            prev_valid = valid;
            if (frame_err)  ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (!rst_n) begin
                cur_busy = 0;
            end else if (busy) begin
                cur_busy++;
            end else if (cur_busy > 0) begin
                last_busy = cur_busy;
                cur_busy  = 0;
            end
        end
    end

    initial begin
        int v_snap;
        int f_snap;

        // Reset state
        settle(3);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        rst_n = 1'b1;
        settle(5);

        // Single good frame 0xA5
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ^8'hA5, 1'b1, CPB);
        settle(20);
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_ferr_cnt", ferr_cnt, 0);
        check("a5_data", {24'd0, data}, 32'h0000_00A5);
        check("a5_sb_empty", exp_q.size(), 0);
        check_rng("a5_busy_len", last_busy, FRAME_BUSY - 2, FRAME_BUSY + 2);

        // Back-to-back 0x00 then 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, ^8'h00, 1'b1, CPB);
        send_byte(8'hFF, ^8'hFF, 1'b1, CPB);
        settle(20);
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_data", {24'd0, data}, 32'h0000_00FF);
        check("b2b_sb_empty", exp_q.size(), 0);

        // 4-cycle glitch on idle line
        last_busy = 0;
        send_bit(1'b0, 4);
        send_bit(1'b1, 30);
        settle(1);
        check_rng("glitch_busy_len", last_busy, 1, CPB);
        check("glitch_valid_cnt", valid_cnt, 3);
        check("glitch_ferr_cnt", ferr_cnt, 0);
        check("glitch_data", {24'd0, data}, 32'h0000_00FF);

        // 0x3C with stop bit held low for 40 cycles
        send_byte(8'h3C, ^8'h3C, 1'b0, 40);
        #1;
        check("ferr_busy_held", {31'd0, busy}, 32'd1);
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_valid_cnt", valid_cnt, 3);
        check("ferr_data", {24'd0, data}, 32'h0000_00FF);
        send_bit(1'b1, 10);
        settle(1);
        check("ferr_busy_release", {31'd0, busy}, 32'd0);
        check("ferr_cnt_once", ferr_cnt, 1);

        // Reset in the middle of data bit 3 of 0x5A, then 0x81
        v_snap = valid_cnt;
        f_snap = ferr_cnt;
        send_bit(1'b0, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        rx = 1'b1;
        settle(5);
        rst_n = 1'b1;
        settle(CPB * 3);
        check("mid_rst_no_valid", valid_cnt, v_snap);
        check("mid_rst_no_ferr", ferr_cnt, f_snap);
        check("mid_rst_busy_idle", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, ^8'h81, 1'b1, CPB);
        settle(20);
        check("post_rst_data", {24'd0, data}, 32'h0000_0081);
        check("post_rst_valid_cnt", valid_cnt, v_snap + 1);
        check("post_rst_sb_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // Bad parity then good parity for 0x01
        send_byte(8'h01, 1'b0, 1'b1, CPB);
        settle(20);
        check("par_bad_perr_cnt", perr_cnt, 1);
        check("par_bad_valid_cnt", valid_cnt, v_snap + 1);
        check("par_bad_data", {24'd0, data}, 32'h0000_0081);
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1, 1'b1, CPB);
        settle(20);
        check("par_good_valid_cnt", valid_cnt, v_snap + 2);
        check("par_good_data", {24'd0, data}, 32'h0000_0001);
        check("par_good_perr_cnt", perr_cnt, 1);
        check("par_good_sb_empty", exp_q.size(), 0);
`else
        check("no_parity_perr_cnt", perr_cnt, 0);
        check("no_parity_perr_out", {31'd0, parity_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
